// File: rtl/mem_stage.sv
// EX/MEM pipeline latch and data-memory access stage: captures ex results, runs
// byte/half/word loads and stores over a req/ack port, and registers the writeback result.
//
// state | meaning
// IDLE  | latch accepts ex_* every edge; non-memory results retire one edge later
// REQ   | memory access outstanding; outputs held, pipeline stalled until ack
module mem_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int OP_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic [RADDR_W-1:0] ex_wd_i,
    input  logic               ex_wreg_i,
    input  logic [DATA_W-1:0]  ex_wdata_i,
    input  logic [OP_W-1:0]    ex_aluop_i,
    input  logic [DATA_W-1:0]  ex_mem_addr_i,
    input  logic [DATA_W-1:0]  ex_reg2_i,
    input  logic [DATA_W-1:0]  ex_pc_i,
    output logic               dmem_req_o,
    output logic               dmem_we_o,
    output logic [3:0]         dmem_be_o,
    output logic [DATA_W-1:0]  dmem_addr_o,
    output logic [DATA_W-1:0]  dmem_wdata_o,
    input  logic               dmem_ack_i,
    input  logic [DATA_W-1:0]  dmem_rdata_i,
    output logic [RADDR_W-1:0] wb_wd_o,
    output logic               wb_wreg_o,
    output logic [DATA_W-1:0]  wb_wdata_o,
    output logic [DATA_W-1:0]  wb_pc_o,
    output logic               addr_err_o,
    output logic               stallreq_o
);

    localparam logic [OP_W-1:0] OP_NOP = OP_W'(8'h00);
    localparam logic [OP_W-1:0] OP_LB  = OP_W'(8'he0);
    localparam logic [OP_W-1:0] OP_LH  = OP_W'(8'he1);
    localparam logic [OP_W-1:0] OP_LW  = OP_W'(8'he3);
    localparam logic [OP_W-1:0] OP_SB  = OP_W'(8'he8);
    localparam logic [OP_W-1:0] OP_SH  = OP_W'(8'he9);
    localparam logic [OP_W-1:0] OP_SW  = OP_W'(8'heb);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [RADDR_W-1:0] l_wd;
    logic               l_wreg;
    logic [DATA_W-1:0]  l_wdata;
    logic [OP_W-1:0]    l_aluop;
    logic [DATA_W-1:0]  l_pc;
    logic [1:0]         l_alo;
    logic               l_err;

    logic               ex_mem, ex_we, ex_mis, ex_go, cap_en;
    logic [3:0]         ex_be;
    logic [DATA_W-1:0]  ex_wdata;
    logic               l_load;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [DATA_W-1:0]  ld_data;

    // Decode the incoming ex op directly so the request issues at its capture edge.
    always_comb begin
        ex_mem   = 1'b0;
        ex_mis   = 1'b0;
        ex_be    = 4'b0000;
        ex_wdata = ex_reg2_i;
        case (ex_aluop_i)
            OP_LB, OP_SB: begin
                ex_mem   = 1'b1;
                ex_be    = 4'b0001 << ex_mem_addr_i[1:0];
                ex_wdata = {4{ex_reg2_i[7:0]}};
            end
            OP_LH, OP_SH: begin
                ex_mem   = 1'b1;
                ex_mis   = ex_mem_addr_i[0];
                ex_be    = ex_mem_addr_i[1] ? 4'b1100 : 4'b0011;
                ex_wdata = {2{ex_reg2_i[15:0]}};
            end
            OP_LW, OP_SW: begin
                ex_mem = 1'b1;
                ex_mis = |ex_mem_addr_i[1:0];
                ex_be  = 4'b1111;
            end
            default: ;
        endcase
        ex_we = (ex_aluop_i == OP_SB) | (ex_aluop_i == OP_SH) | (ex_aluop_i == OP_SW);
        ex_go = ex_mem & ~ex_mis & ~flush_i;
    end

    always_comb begin
        l_load  = (l_aluop == OP_LB) | (l_aluop == OP_LH) | (l_aluop == OP_LW);
        ld_byte = dmem_rdata_i[{l_alo, 3'b000} +: 8];
        ld_half = dmem_rdata_i[{l_alo[1], 4'b0000} +: 16];
        case (l_aluop)
            OP_LB:   ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            OP_LH:   ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        stallreq_o = 1'b0;
        cap_en     = 1'b0;
        case (state)
            IDLE: begin
                cap_en = 1'b1;
                if (ex_go) state_nxt = REQ;
            end
            REQ: begin
                stallreq_o = ~dmem_ack_i;
                cap_en     = dmem_ack_i;
                if (dmem_ack_i) state_nxt = ex_go ? REQ : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_be_o    <= 4'b0000;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            wb_wd_o      <= '0;
            wb_wreg_o    <= 1'b0;
            wb_wdata_o   <= '0;
            wb_pc_o      <= '0;
            addr_err_o   <= 1'b0;
            l_wd         <= '0;
            l_wreg       <= 1'b0;
            l_wdata      <= '0;
            l_aluop      <= OP_NOP;
            l_pc         <= '0;
            l_alo        <= 2'b00;
            l_err        <= 1'b0;
        end else begin
            if (state == IDLE) begin
                wb_wd_o    <= l_wd;
                wb_wreg_o  <= l_wreg & ~l_err;
                wb_wdata_o <= l_wdata;
                wb_pc_o    <= l_pc;
                addr_err_o <= l_err;
            end else if (dmem_ack_i) begin
                dmem_req_o <= 1'b0;
                wb_wd_o    <= l_wd;
                wb_pc_o    <= l_pc;
                addr_err_o <= 1'b0;
                if (l_load) begin
                    wb_wdata_o <= ld_data;
                    wb_wreg_o  <= l_wreg & ~flush_i;
                end else begin
                    wb_wreg_o  <= 1'b0;
                end
            end else begin
                // A flush while waiting only kills the result; the access itself completes.
                wb_wreg_o  <= 1'b0;
                addr_err_o <= 1'b0;
                if (flush_i) l_wreg <= 1'b0;
            end

            if (cap_en) begin
                l_wd    <= ex_wd_i;
                l_wdata <= ex_wdata_i;
                l_pc    <= ex_pc_i;
                l_alo   <= ex_mem_addr_i[1:0];
                l_wreg  <= ex_wreg_i & ~flush_i;
                l_aluop <= flush_i ? OP_NOP : ex_aluop_i;
                l_err   <= ex_mem & ex_mis & ~flush_i;
                if (ex_go) begin
                    dmem_req_o   <= 1'b1;
                    dmem_we_o    <= ex_we;
                    dmem_be_o    <= ex_be;
                    dmem_addr_o  <= {ex_mem_addr_i[DATA_W-1:2], 2'b00};
                    dmem_wdata_o <= ex_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases then randomized instructions checked against a
// transaction-level model of loads, stores, lane selection and writeback timing.
module tb_mem_stage;

    localparam logic [7:0] NOP  = 8'h00;
    localparam logic [7:0] LB   = 8'he0;
    localparam logic [7:0] LH   = 8'he1;
    localparam logic [7:0] LW   = 8'he3;
    localparam logic [7:0] SB   = 8'he8;
    localparam logic [7:0] SH   = 8'he9;
    localparam logic [7:0] SW   = 8'heb;
    localparam logic [7:0] ORI  = 8'h25;
    localparam logic [7:0] ADDU = 8'h21;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr, reg2, wdata, pc;
        logic [4:0]  wd;
        logic        wreg, flush;
    } instr_t;

    logic        clk = 1'b0, rst, flush_i;
    logic [4:0]  ex_wd_i;
    logic        ex_wreg_i;
    logic [31:0] ex_wdata_i, ex_mem_addr_i, ex_reg2_i, ex_pc_i;
    logic [7:0]  ex_aluop_i;
    logic        dmem_req_o, dmem_we_o, dmem_ack_i;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [4:0]  wb_wd_o;
    logic        wb_wreg_o, addr_err_o, stallreq_o;
    logic [31:0] wb_wdata_o, wb_pc_o;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] optab [8] = '{LB, LH, LW, SB, SH, SW, ORI, ADDU};

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i), .ex_wdata_i(ex_wdata_i),
        .ex_aluop_i(ex_aluop_i), .ex_mem_addr_i(ex_mem_addr_i), .ex_reg2_i(ex_reg2_i),
        .ex_pc_i(ex_pc_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .wb_wd_o(wb_wd_o), .wb_wreg_o(wb_wreg_o), .wb_wdata_o(wb_wdata_o),
        .wb_pc_o(wb_pc_o), .addr_err_o(addr_err_o), .stallreq_o(stallreq_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_mem(input logic [7:0] op);
        return op == LB || op == LH || op == LW || op == SB || op == SH || op == SW;
    endfunction

    function automatic bit is_load(input logic [7:0] op);
        return op == LB || op == LH || op == LW;
    endfunction

    function automatic int size_of(input logic [7:0] op);
        if (op == LB || op == SB) return 1;
        if (op == LH || op == SH) return 2;
        return 4;
    endfunction

    function automatic bit misal(input logic [7:0] op, input logic [31:0] addr);
        return is_mem(op) && (addr % size_of(op)) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [7:0] op, input int a);
        if (size_of(op) == 1) return 4'(2 ** a);
        if (size_of(op) == 2) return (a >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] exp_sdata(input logic [7:0] op, input logic [31:0] r);
        if (size_of(op) == 1) return (r % 256) * 32'h0101_0101;
        if (size_of(op) == 2) return (r % 65536) * 32'h0001_0001;
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [7:0] op, input int a, input logic [31:0] rd);
        int v;
        if (size_of(op) == 1) begin
            v = int'((rd >> (8 * a)) % 256);
            if (v >= 128) v -= 256;
            return 32'(v);
        end
        if (size_of(op) == 2) begin
            v = int'((a >= 2) ? rd / 65536 : rd % 65536);
            if (v >= 32768) v -= 65536;
            return 32'(v);
        end
        return rd;
    endfunction

    task automatic drive(input instr_t i);
        ex_aluop_i    = i.op;
        ex_mem_addr_i = i.addr;
        ex_reg2_i     = i.reg2;
        ex_wdata_i    = i.wdata;
        ex_pc_i       = i.pc;
        ex_wd_i       = i.wd;
        ex_wreg_i     = i.wreg;
        flush_i       = i.flush;
    endtask

    task automatic bubble();
        ex_aluop_i    = NOP;
        ex_wreg_i     = 1'b0;
        ex_wd_i       = 5'($urandom);
        ex_wdata_i    = $urandom;
        ex_mem_addr_i = $urandom;
        ex_reg2_i     = $urandom;
        ex_pc_i       = $urandom;
        flush_i       = 1'b0;
    endtask

    function automatic instr_t mk(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                                  input logic [31:0] wdata, input logic [4:0] wd, input logic [31:0] pc);
        instr_t i;
        i.op = op; i.addr = addr; i.reg2 = reg2; i.wdata = wdata; i.wd = wd;
        i.wreg = !(op == SB || op == SH || op == SW); i.pc = pc; i.flush = 1'b0;
        return i;
    endfunction

    function automatic instr_t rnd_instr(input bit nonmem_only);
        instr_t i;
        i = mk(nonmem_only ? optab[$urandom_range(6, 7)] : optab[$urandom_range(0, 7)],
               $urandom, $urandom, $urandom, 5'($urandom), $urandom & 32'hffff_fffc);
        i.wreg  = i.wreg & ($urandom_range(0, 7) != 0);
        i.flush = ($urandom_range(0, 7) == 0);
        return i;
    endfunction

    // fk: 0 no follower, 1 follower captured at ack edge, 2 follower captured with flush
    task automatic run_one(input instr_t a, input int delay, input bit fw, input int fk, input logic [31:0] rd);
        instr_t b;
        bit go, flushed;
        int lane;
        lane = int'(a.addr % 4);
        go = is_mem(a.op) && !a.flush && !misal(a.op, a.addr);
        drive(a);
        if (!go) dmem_ack_i = 1'($urandom_range(0, 1));
        tick();
        dmem_ack_i = 1'b0;
        bubble();
        chk("cap_req", dmem_req_o, go);
        if (!go) begin
            chk("idle_stall", stallreq_o, 0);
            tick();
            chk("ret_err", addr_err_o, is_mem(a.op) && !a.flush);
            chk("ret_req", dmem_req_o, 0);
            if (is_mem(a.op) && !a.flush) begin
                chk("err_wreg", wb_wreg_o, 0);
                chk("err_pc", wb_pc_o, a.pc);
            end else begin
                chk("ret_wreg", wb_wreg_o, a.wreg && !a.flush && !is_mem(a.op));
                if (!a.flush && !is_mem(a.op)) begin
                    chk("ret_wd", wb_wd_o, a.wd);
                    chk("ret_wdata", wb_wdata_o, a.wdata);
                    chk("ret_pc", wb_pc_o, a.pc);
                end
            end
            tick();
            chk("pulse_wreg", wb_wreg_o, 0);
            chk("pulse_err", addr_err_o, 0);
            return;
        end
        chk("cap_we", dmem_we_o, !is_load(a.op));
        chk("cap_be", dmem_be_o, exp_be(a.op, lane));
        chk("cap_addr", dmem_addr_o, a.addr - a.addr % 4);
        chk("cap_wdata", dmem_wdata_o, exp_sdata(a.op, a.reg2));
        chk("cap_wreg", wb_wreg_o, 0);
        for (int d = 0; d < delay; d++) begin
            flush_i = fw && d == 0;
            #1;
            chk("wait_stall", stallreq_o, 1);
            tick();
            chk("wait_req", dmem_req_o, 1);
            chk("wait_be", dmem_be_o, exp_be(a.op, lane));
            chk("wait_wreg", wb_wreg_o, 0);
        end
        flushed = fw && delay > 0;
        b = rnd_instr(1'b1);
        b.flush = (fk == 2);
        if (fk > 0) drive(b);
        else flush_i = 1'b0;
        flushed = flushed || fk == 2;
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = rd;
        #1;
        chk("ack_stall", stallreq_o, 0);
        tick();
        dmem_ack_i = 1'b0;
        bubble();
        chk("ack_req", dmem_req_o, 0);
        chk("ack_wreg", wb_wreg_o, is_load(a.op) && !flushed && a.wreg);
        chk("ack_err", addr_err_o, 0);
        if (is_load(a.op) && !flushed) begin
            chk("ack_wdata", wb_wdata_o, exp_load(a.op, lane, rd));
            chk("ack_wd", wb_wd_o, a.wd);
            chk("ack_pc", wb_pc_o, a.pc);
        end
        tick();
        if (fk == 1) begin
            chk("fol_wreg", wb_wreg_o, b.wreg);
            chk("fol_wd", wb_wd_o, b.wd);
            chk("fol_wdata", wb_wdata_o, b.wdata);
            chk("fol_pc", wb_pc_o, b.pc);
        end else begin
            chk("post_wreg", wb_wreg_o, 0);
        end
    endtask

    initial begin
        instr_t a;
        rst = 1'b1;
        dmem_ack_i = 1'b0;
        dmem_rdata_i = '0;
        bubble();
        tick();
        tick();
        chk("rst_req", dmem_req_o, 0);
        chk("rst_be", dmem_be_o, 0);
        chk("rst_wreg", wb_wreg_o, 0);
        chk("rst_pc", wb_pc_o, 0);
        chk("rst_stall", stallreq_o, 0);
        rst = 1'b0;

        run_one(mk(ORI, 32'h0, 32'h0, 32'h0000_1234, 5'd5, 32'h0000_0400), 0, 0, 0, 32'h0);
        run_one(mk(LB, 32'h0000_0103, 32'h0, 32'h0, 5'd6, 32'h0000_0404), 3, 0, 0, 32'h80AA_BBCC);
        run_one(mk(SH, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 5'd0, 32'h0000_0408), 0, 0, 0, 32'h0);
        run_one(mk(LW, 32'h0000_0101, 32'h0, 32'h0, 5'd7, 32'h0000_040c), 0, 0, 0, 32'h0);
        run_one(mk(LW, 32'h0000_0100, 32'h0, 32'h0, 5'd8, 32'h0000_0410), 2, 1, 1, 32'hDEAD_BEEF);
        run_one(mk(LH, 32'h0000_0106, 32'h0, 32'h0, 5'd9, 32'h0000_0414), 1, 0, 2, 32'h8001_7FFF);

        // load followed immediately by a store captured at the ack edge
        drive(mk(LW, 32'h0000_0300, 32'h0, 32'h0, 5'd7, 32'h0000_0500));
        tick();
        drive(mk(SW, 32'h0000_0404, 32'hCAFE_F00D, 32'h0, 5'd0, 32'h0000_0504));
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'h1357_9BDF;
        tick();
        bubble();
        chk("b2b_req", dmem_req_o, 1);
        chk("b2b_we", dmem_we_o, 1);
        chk("b2b_addr", dmem_addr_o, 32'h0000_0404);
        chk("b2b_wdata", dmem_wdata_o, 32'hCAFE_F00D);
        chk("b2b_ldwreg", wb_wreg_o, 1);
        chk("b2b_lddata", wb_wdata_o, 32'h1357_9BDF);
        tick();
        dmem_ack_i = 1'b0;
        chk("b2b_req2", dmem_req_o, 0);
        chk("b2b_stwreg", wb_wreg_o, 0);
        tick();

        // reset while a request is outstanding
        drive(mk(LW, 32'h0000_0010, 32'h0, 32'h0, 5'd3, 32'h0000_0600));
        tick();
        bubble();
        chk("prerst_req", dmem_req_o, 1);
        rst = 1'b1;
        tick();
        chk("midrst_req", dmem_req_o, 0);
        chk("midrst_we", dmem_we_o, 0);
        chk("midrst_addr", dmem_addr_o, 0);
        chk("midrst_wdata", dmem_wdata_o, 0);
        chk("midrst_wdataw", wb_wdata_o, 0);
        chk("midrst_err", addr_err_o, 0);
        chk("midrst_stall", stallreq_o, 0);
        rst = 1'b0;

        for (int n = 0; n < 150; n++) begin
            a = rnd_instr(1'b0);
            if ($urandom_range(0, 1) == 1) a.addr = a.addr & 32'hffff_fffc | 32'(size_of(a.op) * $urandom_range(0, 3 / size_of(a.op)));
            run_one(a, $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
